fetch_queue_pc: RTL and testbench

Parametrised successor to the single-cycle PC/incrementer/jump-mux fetch path. It owns the program counter and reads a combinational instruction memory every cycle. Fetched {pc, instruction} pairs are buffered in a DEPTH-entry FIFO with a valid/ready handshake toward decode. Redirects cover branch, J-type with in-block jump-address construction, and register-target jumps; a redirect flushes the queue. Fetch halts on an all-zero instruction word.

---
 rtl/fetch_queue_pc.sv | 143 ++++++++++++++
 tb/tb_fetch_queue_pc.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_pc.sv
// rtl/fetch_queue_pc.sv - program counter, instruction fetch and fetch queue toward decode
//
// Owns the PC and reads a combinational instruction memory at imem_addr each
// cycle. Non-zero words are queued as {pc, instr} pairs in a DEPTH-entry FIFO
// drained through a valid/ready handshake. A redirect (branch, J-type or
// register jump) flushes the queue and reloads the PC. An all-zero word stops
// fetch until the next redirect or reset.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   imem_addr / imem_rdata     fetch address (PC register) / same-cycle data
//   out_valid/out_ready        head-of-queue handshake
//   out_pc/out_instr           head entry contents
//   redirect_*                 fetch stream change request and its target fields
//   halted                     fetch stopped on a zero word
//   misaligned                 one-cycle pulse on a non-J target with low bits set
//   count                      queue occupancy
module fetch_queue_pc #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h00400000)
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    input  logic                       redirect_valid,
    input  logic                       redirect_jtype,
    input  logic [ADDR_W-1:0]          redirect_target,
    input  logic [25:0]                redirect_index,
    input  logic [ADDR_W-1:0]          redirect_src_pc,
    output logic                       halted,
    output logic                       misaligned,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Bits replaced by {instr_index, 2'b00} in a J-type target; everything
    // above them comes from the delay-slot PC (src_pc + 4).
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(28'hFFF_FFFF);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               halted_q, halted_d;
    logic               misaligned_q, misaligned_d;

    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic               pop;
    logic               fetch_ok;
    logic               push;
    logic               halt_hit;
    logic [ADDR_W-1:0]  src_plus4;
    logic [ADDR_W-1:0]  jump_target;
    logic [ADDR_W-1:0]  redir_pc;

    assign imem_addr  = pc_q;
    assign out_valid  = (count_q != '0);
    assign out_pc     = pc_mem[rd_ptr_q];
    assign out_instr  = instr_mem[rd_ptr_q];
    assign halted     = halted_q;
    assign misaligned = misaligned_q;
    assign count      = count_q;

    always_comb begin
        pop         = out_valid & out_ready;
        // Full test uses the pre-pop occupancy: a full queue never pushes,
        // even when the head leaves in the same cycle.
        fetch_ok    = !redirect_valid && !halted_q && (count_q < CNT_W'(DEPTH));
        push        = fetch_ok && (imem_rdata != '0);
        halt_hit    = fetch_ok && (imem_rdata == '0);
        src_plus4   = redirect_src_pc + ADDR_W'(4);
        jump_target = (src_plus4 & ~LOW_MASK) | ADDR_W'({redirect_index, 2'b00});
        redir_pc    = redirect_jtype ? jump_target : redirect_target;

        pc_d         = pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        halted_d     = halted_q;
        misaligned_d = 1'b0;

        if (redirect_valid) begin
            // Flush wins over any push/pop; a same-cycle pop still counts as
            // delivered from the consumer's point of view.
            pc_d         = {redir_pc[ADDR_W-1:2], 2'b00};
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            halted_d     = 1'b0;
            misaligned_d = !redirect_jtype && (redirect_target[1:0] != 2'b00);
        end else begin
            if (push) begin
                pc_d     = pc_q + ADDR_W'(4);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (halt_hit) begin
                halted_d = 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            halted_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            halted_q     <= halted_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Queue storage is never cleared; only the pointers and count are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= pc_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue_pc.sv
// tb/tb_fetch_queue_pc.sv - self-checking bench for fetch_queue_pc
module tb_fetch_queue_pc;

    localparam logic [31:0] BASE = 32'h00400000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        redirect_valid;
    logic        redirect_jtype;
    logic [31:0] redirect_target;
    logic [25:0] redirect_index;
    logic [31:0] redirect_src_pc;
    logic        halted;
    logic        misaligned;
    logic [2:0]  count;

    logic [31:0] mem [64];
    exp_t        sb [$];
    int          n_checks;
    int          n_pass;

    fetch_queue_pc dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .redirect_valid  (redirect_valid),
        .redirect_jtype  (redirect_jtype),
        .redirect_target (redirect_target),
        .redirect_index  (redirect_index),
        .redirect_src_pc (redirect_src_pc),
        .halted          (halted),
        .misaligned      (misaligned),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off < 32'd256) ? mem[off[7:2]] : 32'd0;
    endfunction

    always_comb begin
        imem_rdata = model_rd(imem_addr);
    end

    // Expected stream from a start PC up to (not including) the first zero word.
    task automatic push_stream(input logic [31:0] start);
        logic [31:0] a;
        logic [31:0] w;
        a = start;
        for (int k = 0; k < 64; k++) begin
            w = model_rd(a);
            if (w == 32'd0) break;
            sb.push_back('{pc: a, instr: w});
            a = a + 32'd4;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every completed handshake must match the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_underflow: unexpected pop out_pc=%h out_instr=%h", out_pc, out_instr);
            end else begin
                e = sb.pop_front();
                if (out_pc !== e.pc || out_instr !== e.instr)
                    $display("FAIL sb_pop: got pc=%h instr=%h, want pc=%h instr=%h",
                             out_pc, out_instr, e.pc, e.instr);
                else
                    n_pass++;
            end
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || halted !== 1'b0 ||
            misaligned !== 1'b0 || imem_addr !== BASE)
            $display("FAIL reset_state: valid=%b count=%0d halted=%b mis=%b addr=%h, want 0 0 0 0 %h",
                     out_valid, count, halted, misaligned, imem_addr, BASE);
        else n_pass++;
        reset = 1'b0;
        sb.delete();
        push_stream(BASE);
    endtask

    task automatic test_stream;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== BASE + 32'(4 * k) || count !== 3'd1)
                $display("FAIL stream_%0d: valid=%b pc=%h count=%0d, want 1 %h 1",
                         k, out_valid, out_pc, count, BASE + 32'(4 * k));
            else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (count !== 3'd4 || imem_addr !== BASE + 32'h20 || out_pc !== BASE + 32'h10)
            $display("FAIL backpressure: count=%0d addr=%h head=%h, want 4 %h %h",
                     count, imem_addr, out_pc, BASE + 32'h20, BASE + 32'h10);
        else n_pass++;
    endtask

    task automatic test_full_pop;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (count !== 3'd3 || imem_addr !== BASE + 32'h20)
            $display("FAIL full_pop: count=%0d addr=%h, want 3 %h", count, imem_addr, BASE + 32'h20);
        else n_pass++;
        out_ready = 1'b0;
        tick();
        n_checks++;
        if (count !== 3'd4 || imem_addr !== BASE + 32'h24)
            $display("FAIL full_refill: count=%0d addr=%h, want 4 %h", count, imem_addr, BASE + 32'h24);
        else n_pass++;
        out_ready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_jtype;
        redirect_valid  = 1'b1;
        redirect_jtype  = 1'b1;
        redirect_src_pc = 32'h00400008;
        redirect_index  = 26'h0100010;
        redirect_target = 32'h0;
        tick();
        redirect_valid = 1'b0;
        sb.delete();
        push_stream(32'h00400040);
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 32'h00400040 || misaligned !== 1'b0)
            $display("FAIL jtype_flush: count=%0d valid=%b addr=%h mis=%b, want 0 0 00400040 0",
                     count, out_valid, imem_addr, misaligned);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h00400040 || out_instr !== 32'd17 || count !== 3'd1)
            $display("FAIL jtype_first: valid=%b pc=%h instr=%h count=%0d, want 1 00400040 00000011 1",
                     out_valid, out_pc, out_instr, count);
        else n_pass++;
    endtask

    task automatic test_misaligned;
        redirect_valid  = 1'b1;
        redirect_jtype  = 1'b0;
        redirect_target = 32'h00400046;
        tick();
        redirect_valid = 1'b0;
        sb.delete();
        push_stream(32'h00400044);
        n_checks++;
        if (imem_addr !== 32'h00400044 || misaligned !== 1'b1)
            $display("FAIL misaligned_set: addr=%h mis=%b, want 00400044 1", imem_addr, misaligned);
        else n_pass++;
        tick();
        n_checks++;
        if (misaligned !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h00400044)
            $display("FAIL misaligned_pulse: mis=%b valid=%b pc=%h, want 0 1 00400044",
                     misaligned, out_valid, out_pc);
        else n_pass++;
    endtask

    task automatic test_halt;
        mem[3]          = 32'd0;
        out_ready       = 1'b0;
        redirect_valid  = 1'b1;
        redirect_jtype  = 1'b0;
        redirect_target = BASE;
        tick();
        redirect_valid = 1'b0;
        sb.delete();
        push_stream(BASE);
        repeat (4) tick();
        n_checks++;
        if (halted !== 1'b1 || count !== 3'd3 || imem_addr !== BASE + 32'hC)
            $display("FAIL halt_hit: halted=%b count=%0d addr=%h, want 1 3 %h",
                     halted, count, imem_addr, BASE + 32'hC);
        else n_pass++;
        out_ready = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || halted !== 1'b1 ||
            imem_addr !== BASE + 32'hC || sb.size() != 0)
            $display("FAIL halt_drain: valid=%b count=%0d halted=%b addr=%h left=%0d, want 0 0 1 %h 0",
                     out_valid, count, halted, imem_addr, sb.size(), BASE + 32'hC);
        else n_pass++;
        mem[3]          = 32'd4;
        redirect_valid  = 1'b1;
        redirect_target = BASE;
        tick();
        redirect_valid = 1'b0;
        sb.delete();
        push_stream(BASE);
        n_checks++;
        if (halted !== 1'b0 || imem_addr !== BASE)
            $display("FAIL halt_clear: halted=%b addr=%h, want 0 %h", halted, imem_addr, BASE);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== BASE)
            $display("FAIL halt_resume: valid=%b pc=%h, want 1 %h", out_valid, out_pc, BASE);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== BASE || halted !== 1'b0)
            $display("FAIL reset_mid: count=%0d valid=%b addr=%h halted=%b, want 0 0 %h 0",
                     count, out_valid, imem_addr, halted, BASE);
        else n_pass++;
        sb.delete();
        tick();
        reset = 1'b0;
        push_stream(BASE);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== BASE || out_instr !== 32'd1)
            $display("FAIL reset_restart: valid=%b pc=%h instr=%h, want 1 %h 00000001",
                     out_valid, out_pc, out_instr, BASE);
        else n_pass++;
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        reset           = 1'b1;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_jtype  = 1'b0;
        redirect_target = 32'h0;
        redirect_index  = 26'h0;
        redirect_src_pc = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1);

        test_reset();
        test_stream();
        test_backpressure();
        test_full_pop();
        test_jtype();
        test_misaligned();
        test_halt();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
